mult: RTL and testbench

//  Bit-serial signed fixed-point multiplier for one neuron synapse in the accelerator.

---
 rtl/mult_pkg.sv | 29 ++
 rtl/mult_sat.sv | 11 +
 rtl/mult.sv | 67 ++++++
 tb/tb_mult.sv | 130 +++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the neuron datapath: Q8.8 widths, saturation limits,
// and the arithmetic shift-and-saturate helper used wherever a wide sum is narrowed.
package mult_pkg;

    localparam int DATA_W = 16;
    localparam int FRAC_W = 8;
    localparam int ACC_W  = 2 * DATA_W;
    localparam int CNT_W  = $clog2(DATA_W);

    localparam logic signed [DATA_W-1:0] Q_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] Q_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    // Saturation limits expressed at accumulator width for signed comparison
    localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-DATA_W){1'b0}}, Q_MAX};
    localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-DATA_W){1'b1}}, Q_MIN};

    function automatic logic signed [DATA_W-1:0] sat_shift(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] s;
        s = v >>> FRAC_W;
        if (s > SAT_HI) begin
            return Q_MAX;
        end else if (s < SAT_LO) begin
            return Q_MIN;
        end else begin
            return s[DATA_W-1:0];
        end
    endfunction

endpackage

// File: rtl/mult_sat.sv
// Combinational narrowing of a full-width product back to Q8.8: floor shift then clamp.
module mult_sat
    import mult_pkg::*;
(
    input  logic signed [ACC_W-1:0]  acc,
    output logic signed [DATA_W-1:0] sat
);

    assign sat = sat_shift(acc);

endmodule

// File: rtl/mult.sv
// Bit-serial signed multiplier: parallel activation times serial LSB-first weight,
// one partial product per enabled clock, saturated Q8.8 result after DATA_W bits.
module mult
    import mult_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] input_neuron,
    input  logic              Weight_bit,
    input  logic              enable,
    output logic [DATA_W-1:0] out,
    output logic              done
);

    logic [CNT_W-1:0]         k_reg;
    logic [DATA_W-1:0]        operand_reg;
    logic signed [ACC_W-1:0]  acc_reg;
    logic signed [ACC_W-1:0]  acc_next;
    logic signed [ACC_W-1:0]  term;
    logic [DATA_W-1:0]        operand_eff;
    logic                     first_bit;
    logic                     last_bit;
    logic signed [DATA_W-1:0] sat_out;

    // On bit 0 the live input is used directly so the latch costs no extra cycle
    always_comb begin
        first_bit   = (k_reg == '0);
        last_bit    = (k_reg == CNT_W'(DATA_W-1));
        operand_eff = first_bit ? input_neuron : operand_reg;
        term        = {{(ACC_W-DATA_W){operand_eff[DATA_W-1]}}, operand_eff};
        term        = term <<< k_reg;
        acc_next    = first_bit ? '0 : acc_reg;
        if (Weight_bit) begin
            // The top weight bit carries negative weight in two's complement
            acc_next = last_bit ? (acc_next - term) : (acc_next + term);
        end
    end

    mult_sat u_sat (
        .acc (acc_next),
        .sat (sat_out)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k_reg       <= '0;
            operand_reg <= '0;
            acc_reg     <= '0;
            out         <= '0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (enable) begin
                k_reg   <= last_bit ? '0 : k_reg + CNT_W'(1);
                acc_reg <= acc_next;
                if (first_bit) begin
                    operand_reg <= input_neuron;
                end
                if (last_bit) begin
                    out  <= sat_out;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mult.sv
// Scoreboard bench for the serial multiplier: stimulus queues expected products,
// a negedge monitor pops one per done pulse.
module tb_mult;
    import mult_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] input_neuron;
    logic              Weight_bit;
    logic              enable;
    logic [DATA_W-1:0] out;
    logic              done;

    logic [DATA_W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int n_ops = 0;
    logic done_prev = 1'b0;

    always #5 clk = ~clk;

    mult dut (
        .clk          (clk),
        .reset        (reset),
        .input_neuron (input_neuron),
        .Weight_bit   (Weight_bit),
        .enable       (enable),
        .out          (out),
        .done         (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            check("done_width", {31'd0, done_prev}, 32'd0);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got out=%h required no completion", out);
            end else begin
                logic [DATA_W-1:0] e;
                e = exp_q.pop_front();
                n_ops++;
                $display("op %0d: out=%h expected=%h", n_ops, out, e);
                check("out", {16'd0, out}, {16'd0, e});
            end
        end
        done_prev = done;
    end

    // Drives nbits weight bits back to back; optional pause after one bit, optional
    // scrambling of input_neuron once bit 0 has been taken.
    task automatic run_op(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] w,
                          input logic [DATA_W-1:0] expv, input bit push, input int nbits,
                          input int pause_after, input bit scramble);
        logic [DATA_W-1:0] held;
        if (push) exp_q.push_back(expv);
        for (int i = 0; i < nbits; i++) begin
            input_neuron = (scramble && i > 0) ? DATA_W'($urandom) : a;
            Weight_bit   = w[i];
            enable       = 1'b1;
            @(posedge clk);
            #1;
            if (i < DATA_W-1) check("done_low", {31'd0, done}, 32'd0);
            else              check("done_pulse", {31'd0, done}, 32'd1);
            if (i == pause_after) begin
                held         = out;
                enable       = 1'b0;
                Weight_bit   = ~Weight_bit;
                input_neuron = ~a;
                for (int p = 0; p < 5; p++) begin
                    @(posedge clk);
                    #1;
                    check("pause_done", {31'd0, done}, 32'd0);
                    check("pause_out", {16'd0, out}, {16'd0, held});
                end
            end
        end
    endtask

    initial begin
        reset        = 1'b1;
        enable       = 1'b0;
        Weight_bit   = 1'b0;
        input_neuron = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out", {16'd0, out}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        reset = 1'b0;

        run_op(16'h0100, 16'h0200, 16'h0200, 1'b1, 16, -1, 1'b0);
        run_op(16'hFF00, 16'h0180, 16'hFE80, 1'b1, 16, -1, 1'b0);
        run_op(16'h0100, 16'hFF00, 16'hFF00, 1'b1, 16, -1, 1'b0);
        run_op(16'h0801, 16'h5555, 16'h7FFF, 1'b1, 16, -1, 1'b0);
        run_op(16'h8000, 16'h7FFF, 16'h8000, 1'b1, 16, -1, 1'b0);
        run_op(16'h0001, 16'hFFFF, 16'hFFFF, 1'b1, 16, -1, 1'b0);
        run_op(16'h0100, 16'h0200, 16'h0200, 1'b1, 16, -1, 1'b1);
        run_op(16'h0100, 16'h0200, 16'h0200, 1'b1, 16, 7, 1'b0);

        // Abort a product after bit 9; reset must clear out asynchronously
        run_op(16'h7FFF, 16'h7FFF, 16'h0000, 1'b0, 10, -1, 1'b0);
        enable = 1'b0;
        reset  = 1'b1;
        #1;
        check("abort_out", {16'd0, out}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        run_op(16'h0100, 16'h0300, 16'h0300, 1'b1, 16, -1, 1'b0);
        run_op(16'h0100, 16'h0200, 16'h0200, 1'b1, 16, -1, 1'b0);
        enable = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
